memory_writeback_stage: RTL and testbench

- MEM/WB pipeline register plus writeback logic for the 5-stage RV32I core.
- Captures memory-stage results each cycle, then aligns and sign/zero-extends load data.
- Selects the final result and drives RegWriteW, RdW and ResultW into register_file.
- Keeps a 64-bit retired-instruction counter for the instret CSR.

---
 rtl/riscv_pkg.sv | 19 +
 rtl/load_extend.sv | 33 +++
 rtl/memory_writeback_stage.sv | 94 +++++++++
 tb/tb_memory_writeback_stage.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the writeback path: datapath width,
// result-source encoding and load funct3 codes.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10
  } result_src_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Load alignment: picks the byte/halfword addressed by the low address bits
// out of the raw memory word and sign- or zero-extends it.
module load_extend
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign shifted  = word >> {offset, 3'b000};
  assign byte_sel = shifted[7:0];
  // Halfword loads ignore offset[0]; misaligned halves are not split.
  assign half_sel = offset[1] ? word[31:16] : word[15:0];

  always_comb begin
    data = word;
    unique case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {24'h0, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data = {16'h0, half_sel};
      F3_LW:   data = word;
      default: data = word;
    endcase
  end

endmodule

// File: rtl/memory_writeback_stage.sv
// MEM/WB pipeline register, writeback result selection and the
// retired-instruction counter feeding instret.
module memory_writeback_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             validM,
  input  logic             RegWriteM,
  input  logic [1:0]       ResultSrcM,
  input  logic [2:0]       funct3M,
  input  logic [4:0]       RdM,
  input  logic [XLEN-1:0]  ALUResultM,
  input  logic [XLEN-1:0]  ReadDataM,
  input  logic [XLEN-1:0]  PCPlus4M,
  input  logic             StallW,
  input  logic             FlushW,
  output logic             RegWriteW,
  output logic [4:0]       RdW,
  output logic [XLEN-1:0]  ResultW,
  output logic [CNT_W-1:0] InstRetW
);
  import riscv_pkg::*;

  typedef struct packed {
    logic            valid;
    logic            regwrite;
    logic [4:0]      rd;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] rdata;
    logic [XLEN-1:0] pc4;
    logic [2:0]      funct3;
    logic [1:0]      resultsrc;
  } wreg_t;

  wreg_t            w_d, w_q;
  logic [CNT_W-1:0] instret_d, instret_q;
  logic             retire;
  logic [31:0]      ld_data;

  // Count at entry only, so a stalled instruction is never counted twice.
  assign retire = validM & ~StallW & ~FlushW;

  always_comb begin
    w_d       = w_q;
    instret_d = instret_q + (retire ? CNT_W'(1) : CNT_W'(0));
    if (FlushW) begin
      w_d = '0;
    end else if (!StallW) begin
      w_d.valid     = validM;
      w_d.regwrite  = RegWriteM;
      w_d.rd        = RdM;
      w_d.alu       = ALUResultM;
      w_d.rdata     = ReadDataM;
      w_d.pc4       = PCPlus4M;
      w_d.funct3    = funct3M;
      w_d.resultsrc = ResultSrcM;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_q       <= '0;
      instret_q <= '0;
    end else begin
      w_q       <= w_d;
      instret_q <= instret_d;
    end
  end

  load_extend u_load_extend (
    .funct3 (w_q.funct3),
    .offset (w_q.alu[1:0]),
    .word   (w_q.rdata[31:0]),
    .data   (ld_data)
  );

  always_comb begin
    ResultW = '0;
    unique case (w_q.resultsrc)
      RES_ALU:  ResultW = w_q.alu;
      RES_LOAD: ResultW = XLEN'(ld_data);
      RES_PC4:  ResultW = w_q.pc4;
      default:  ResultW = '0;
    endcase
  end

  // x0 is hardwired zero, so never present a write to it.
  assign RegWriteW = w_q.valid & w_q.regwrite & (w_q.rd != 5'd0);
  assign RdW       = w_q.rd;
  assign InstRetW  = instret_q;

endmodule

// File: tb/tb_memory_writeback_stage.sv
// Directed bench for memory_writeback_stage: a vector table for single-cycle
// behaviour plus hand sequences for stall/flush, async reset and counter wrap.
module tb_memory_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        validM, RegWriteM, StallW, FlushW;
  logic [1:0]  ResultSrcM;
  logic [2:0]  funct3M;
  logic [4:0]  RdM;
  logic [31:0] ALUResultM, ReadDataM, PCPlus4M;

  logic        RegWriteW, RegWriteW_s;
  logic [4:0]  RdW, RdW_s;
  logic [31:0] ResultW, ResultW_s;
  logic [63:0] InstRetW;
  logic [2:0]  InstRetW_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  memory_writeback_stage #(.XLEN(32), .CNT_W(64)) dut (
    .clk(clk), .rst(rst), .validM(validM), .RegWriteM(RegWriteM),
    .ResultSrcM(ResultSrcM), .funct3M(funct3M), .RdM(RdM),
    .ALUResultM(ALUResultM), .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M),
    .StallW(StallW), .FlushW(FlushW), .RegWriteW(RegWriteW), .RdW(RdW),
    .ResultW(ResultW), .InstRetW(InstRetW)
  );

  // Narrow-counter instance: exercises wrap-around in a handful of cycles.
  memory_writeback_stage #(.XLEN(32), .CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .validM(validM), .RegWriteM(RegWriteM),
    .ResultSrcM(ResultSrcM), .funct3M(funct3M), .RdM(RdM),
    .ALUResultM(ALUResultM), .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M),
    .StallW(StallW), .FlushW(FlushW), .RegWriteW(RegWriteW_s), .RdW(RdW_s),
    .ResultW(ResultW_s), .InstRetW(InstRetW_s)
  );

  typedef struct {
    string       name;
    logic        v, rw;
    logic [1:0]  src;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] alu, rdata, pc4;
    logic        ewe;
    logic [4:0]  erd;
    logic [31:0] eres;
    logic [63:0] ecnt;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic [1:0] src,
                       input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] rdata,
                       input logic [31:0] pc4);
    validM = v; RegWriteM = rw; ResultSrcM = src; funct3M = f3; RdM = rd;
    ALUResultM = alu; ReadDataM = rdata; PCPlus4M = pc4;
  endtask

  task automatic chk_out(input string name, input logic we, input logic [4:0] rd,
                         input logic [31:0] res, input logic [63:0] cnt);
    chk({name, ".we"},  {63'd0, RegWriteW}, {63'd0, we});
    chk({name, ".rd"},  {59'd0, RdW}, {59'd0, rd});
    chk({name, ".res"}, {32'd0, ResultW}, {32'd0, res});
    chk({name, ".cnt"}, InstRetW, cnt);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    localparam logic [31:0] RD = 32'h80FF_7F01;
    tbl[0]  = '{"alu",     1, 1, 2'b00, 3'b000, 5'd5, 32'h0000_000D, 32'h0, 32'h0,   1, 5'd5, 32'd13,          64'd1};
    tbl[1]  = '{"lb_o2",   1, 1, 2'b01, 3'b000, 5'd6, 32'h0000_1002, RD,    32'h0,   1, 5'd6, 32'hFFFF_FFFF,   64'd2};
    tbl[2]  = '{"lbu_o3",  1, 1, 2'b01, 3'b100, 5'd6, 32'h0000_1003, RD,    32'h0,   1, 5'd6, 32'h0000_0080,   64'd3};
    tbl[3]  = '{"lh_o0",   1, 1, 2'b01, 3'b001, 5'd7, 32'h0000_1000, RD,    32'h0,   1, 5'd7, 32'h0000_7F01,   64'd4};
    tbl[4]  = '{"lhu_o2",  1, 1, 2'b01, 3'b101, 5'd7, 32'h0000_1002, RD,    32'h0,   1, 5'd7, 32'h0000_80FF,   64'd5};
    tbl[5]  = '{"lw",      1, 1, 2'b01, 3'b010, 5'd8, 32'h0000_1001, RD,    32'h0,   1, 5'd8, 32'h80FF_7F01,   64'd6};
    tbl[6]  = '{"lh_o1",   1, 1, 2'b01, 3'b001, 5'd8, 32'h0000_1001, RD,    32'h0,   1, 5'd8, 32'h0000_7F01,   64'd7};
    tbl[7]  = '{"lb_o0",   1, 1, 2'b01, 3'b000, 5'd9, 32'h0000_1000, RD,    32'h0,   1, 5'd9, 32'h0000_0001,   64'd8};
    tbl[8]  = '{"lb_o3",   1, 1, 2'b01, 3'b000, 5'd9, 32'h0000_1003, RD,    32'h0,   1, 5'd9, 32'hFFFF_FF80,   64'd9};
    tbl[9]  = '{"lh_o3",   1, 1, 2'b01, 3'b001, 5'd9, 32'h0000_1003, RD,    32'h0,   1, 5'd9, 32'hFFFF_80FF,   64'd10};
    tbl[10] = '{"f3_undef",1, 1, 2'b01, 3'b011, 5'd10,32'h0000_1001, RD,    32'h0,   1, 5'd10,32'h80FF_7F01,   64'd11};
    tbl[11] = '{"jal",     1, 1, 2'b10, 3'b000, 5'd1, 32'h0000_0055, 32'h0, 32'h104, 1, 5'd1, 32'h0000_0104,   64'd12};
    tbl[12] = '{"jal_x0",  1, 1, 2'b10, 3'b000, 5'd0, 32'h0000_0055, 32'h0, 32'h104, 0, 5'd0, 32'h0000_0104,   64'd13};
    tbl[13] = '{"src11",   1, 1, 2'b11, 3'b000, 5'd11,32'h0000_0077, RD,    32'h104, 1, 5'd11,32'h0,           64'd14};
    tbl[14] = '{"bubble",  0, 1, 2'b00, 3'b000, 5'd12,32'h0000_0033, 32'h0, 32'h0,   0, 5'd12,32'h0000_0033,   64'd14};
    tbl[15] = '{"no_wr",   1, 0, 2'b00, 3'b000, 5'd13,32'h0000_0044, 32'h0, 32'h0,   0, 5'd13,32'h0000_0044,   64'd15};

    rst = 1'b0; StallW = 1'b0; FlushW = 1'b0;
    drive(0, 0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
    step();
    chk_out("reset", 0, 5'd0, 32'h0, 64'd0);
    step();
    rst = 1'b1;
    step();
    chk_out("post_reset", 0, 5'd0, 32'h0, 64'd0);

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].v, tbl[i].rw, tbl[i].src, tbl[i].f3, tbl[i].rd,
            tbl[i].alu, tbl[i].rdata, tbl[i].pc4);
      step();
      chk_out(tbl[i].name, tbl[i].ewe, tbl[i].erd, tbl[i].eres, tbl[i].ecnt);
    end

    // Stall holds W and counts the held instruction only once.
    drive(1, 1, 2'b00, 3'b000, 5'd3, 32'd10, 32'h0, 32'h0);
    step();
    chk_out("stall_cap", 1, 5'd3, 32'd10, 64'd16);
    StallW = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 2'b10, 3'b000, 5'(20 + i), 32'(99 + i), 32'h0, 32'h200);
      step();
      chk_out("stall_hold", 1, 5'd3, 32'd10, 64'd16);
    end
    FlushW = 1'b1;
    step();
    chk_out("flush", 0, 5'd0, 32'h0, 64'd16);
    FlushW = 1'b0; StallW = 1'b0;
    drive(0, 0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
    step();
    chk_out("idle", 0, 5'd0, 32'h0, 64'd16);

    // Reset between edges clears outputs without a clock.
    drive(1, 1, 2'b00, 3'b000, 5'd4, 32'h55, 32'h0, 32'h0);
    step();
    chk_out("pre_async", 1, 5'd4, 32'h55, 64'd17);
    #2 rst = 1'b0;
    #1 chk_out("async_rst", 0, 5'd0, 32'h0, 64'd0);
    chk("async_rst.small_cnt", {61'd0, InstRetW_s}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Eight retirements wrap the 3-bit counter back to zero.
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 2'b00, 3'b000, 5'd2, 32'(i), 32'h0, 32'h0);
      step();
      if (i == 6) chk("wrap.max", {61'd0, InstRetW_s}, 64'd7);
    end
    chk("wrap.zero", {61'd0, InstRetW_s}, 64'd0);
    chk("wrap.wide", InstRetW, 64'd8);
    chk("wrap.res", {32'd0, ResultW}, 64'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
